uart_tx_mmio: RTL and testbench

- Memory-mapped 8N1 UART transmitter on the CPU data-memory bus, downstream of the single-cycle core.
- Decodes core stores and loads at a fixed base address, queues bytes in a small FIFO, and serialises them on tx.
- Returns status combinationally, so the single-cycle core reads it without stalling; the top-level uses hit to mux ReadData against data RAM.

---
 rtl/uart_mmio_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_tx_mmio.sv | 149 ++++++++++++++
 tb/tb_uart_tx_mmio.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared register map, STATUS bit positions and transmitter state encoding
// for the memory-mapped UART transmitter.
package uart_mmio_pkg;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;

  localparam int unsigned STAT_FULL   = 0;
  localparam int unsigned STAT_EMPTY  = 1;
  localparam int unsigned STAT_BUSY   = 2;
  localparam int unsigned STAT_OVF    = 3;
  localparam int unsigned STAT_CNT_LO = 4;
  localparam int unsigned STAT_CNT_HI = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and synchronous reset.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, sticky overflow flag,
// TX FIFO and the start/data/stop serialiser.
module uart_tx_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

  tx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             overflow;

  logic [3:0]       offset;
  logic             push_req;
  logic             ovf_set;
  logic             ovf_clr;
  logic             bit_last;

  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [31:0]      status;
  logic             unused_wrdata;

  assign offset        = Mem_WrAddr[3:0];
  assign hit           = (Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
  assign push_req      = MemWrite & hit & (offset == REG_TXDATA);
  assign ovf_clr       = MemWrite & hit & (offset == REG_CTRL) & Mem_WrData[0];
  assign fifo_pop      = (state == S_IDLE) & ~fifo_empty;
  assign ovf_set       = push_req & fifo_full & ~fifo_pop;
  assign bit_last      = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign unused_wrdata = ^Mem_WrData[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (Mem_WrData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                          = '0;
    status[STAT_FULL]               = fifo_full;
    status[STAT_EMPTY]              = fifo_empty;
    status[STAT_BUSY]               = tx_busy;
    status[STAT_OVF]                = overflow;
    status[STAT_CNT_HI:STAT_CNT_LO] = 4'(fifo_count);
    ReadData                        = '0;
    if (hit && (offset == REG_STATUS)) begin
      ReadData = status;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            shift   <= fifo_dout;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            bit_cnt <= '0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            tx_busy <= 1'b0;
            state   <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register-map vector table plus hand-written
// frame, overflow, back-to-back and mid-frame reset sequences.
module tb_uart_tx_mmio;

  localparam int unsigned C    = 4;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic        hit;
  logic        tx;
  logic        tx_busy;

  int checks;
  int errors;

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .ReadData   (ReadData),
    .hit        (hit),
    .tx         (tx),
    .tx_busy    (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_rd, input logic exp_hit);
    Mem_WrAddr = addr;
    #1;
    check({name, " rdata"}, ReadData, exp_rd);
    check({name, " hit"}, {31'd0, hit}, {31'd0, exp_hit});
  endtask

  // Entered on the sample where tx has just fallen; leaves on the idle sample after STOP.
  task automatic check_frame(input logic [7:0] b);
    logic [9:0] frame;
    int         idx;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * C; k++) begin
      idx = k / C;
      check($sformatf("frame %h bit %0d cyc %0d", b, idx, k), {30'd0, tx, tx_busy},
            {30'd0, frame[idx], 1'b1});
      tick();
    end
    check($sformatf("frame %h end", b), {30'd0, tx, tx_busy}, {30'd0, 2'b10});
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWrite   = 1'b1;
    Mem_WrAddr = addr;
    Mem_WrData = data;
    tick();
    MemWrite   = 1'b0;
  endtask

  initial begin
    logic [7:0] d[10];
    bit         seen_idle;

    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    MemWrite   = 1'b0;
    Mem_WrAddr = '0;
    Mem_WrData = '0;

    vecs[0]  = '{1'b0, BASE + 32'h0,  32'h0,  32'h0, 1'b1};
    vecs[1]  = '{1'b0, BASE + 32'h4,  32'h0,  32'h2, 1'b1};
    vecs[2]  = '{1'b0, BASE + 32'h8,  32'h0,  32'h0, 1'b1};
    vecs[3]  = '{1'b0, BASE + 32'hC,  32'h0,  32'h0, 1'b1};
    vecs[4]  = '{1'b0, BASE + 32'h6,  32'h0,  32'h0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,  32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'hFFFF_0014, 32'h0,  32'h0, 1'b0};
    vecs[7]  = '{1'b1, BASE + 32'hC,  32'hAB, 32'h0, 1'b1};
    vecs[8]  = '{1'b1, BASE + 32'h4,  32'hFF, 32'h2, 1'b1};
    vecs[9]  = '{1'b1, BASE + 32'h1,  32'h12, 32'h0, 1'b1};
    vecs[10] = '{1'b1, BASE + 32'h8,  32'h1,  32'h0, 1'b1};
    vecs[11] = '{1'b1, 32'h0000_0000, 32'h77, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'hFFFE_0004, 32'h0,  32'h0, 1'b0};

    d[0] = 8'h01; d[1] = 8'h80; d[2] = 8'hFF; d[3] = 8'h00; d[4] = 8'h5A;
    d[5] = 8'hA5; d[6] = 8'h0F; d[7] = 8'hF0; d[8] = 8'h3C; d[9] = 8'hEE;

    // Reset
    tick();
    tick();
    reset = 1'b0;
    rd_check("reset status", BASE + 32'h4, 32'h2, 1'b1);
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset busy", {31'd0, tx_busy}, 32'd0);

    // Register map table: reads, ignored writes, misses
    for (int i = 0; i < 13; i++) begin
      MemWrite   = vecs[i].mw;
      Mem_WrAddr = vecs[i].addr;
      Mem_WrData = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d rdata", i), ReadData, vecs[i].exp_rd);
      check($sformatf("vec%0d hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
      tick();
      MemWrite = 1'b0;
      rd_check($sformatf("vec%0d status after", i), BASE + 32'h4, 32'h2, 1'b1);
      check($sformatf("vec%0d tx", i), {31'd0, tx}, 32'd1);
    end

    // Single frame 0x55 with push-to-start latency
    store(BASE, 32'h55);
    check("lat edge E tx", {31'd0, tx}, 32'd1);
    check("lat edge E busy", {31'd0, tx_busy}, 32'd0);
    tick();
    check_frame(8'h55);

    // Fill and overflow
    for (int i = 0; i < 10; i++) begin
      MemWrite   = 1'b1;
      Mem_WrAddr = BASE;
      Mem_WrData = {24'd0, d[i]};
      tick();
    end
    MemWrite = 1'b0;
    rd_check("overflow status", BASE + 32'h4, 32'h8D, 1'b1);
    store(BASE + 32'h8, 32'h0);
    rd_check("ctrl bit0=0 keeps ovf", BASE + 32'h4, 32'h8D, 1'b1);
    store(BASE + 32'h8, 32'h1);
    rd_check("ctrl clears ovf", BASE + 32'h4, 32'h85, 1'b1);

    // Drain: remaining frames must come out in order with a single idle cycle between
    seen_idle = 1'b0;
    for (int n = 0; n < 100 && !seen_idle; n++) begin
      tick();
      if (!tx_busy) seen_idle = 1'b1;
    end
    check("drain wait idle", {31'd0, seen_idle}, 32'd1);
    for (int i = 1; i < 9; i++) begin
      tick();
      check_frame(d[i]);
    end
    rd_check("drained status", BASE + 32'h4, 32'h2, 1'b1);

    // Back-to-back frames
    store(BASE, 32'hA3);
    check("b2b first edge tx", {31'd0, tx}, 32'd1);
    store(BASE, 32'h3C);
    check_frame(8'hA3);
    tick();
    check_frame(8'h3C);

    // Reset during DATA bit 3 with a second byte queued
    store(BASE, 32'h5A);
    store(BASE, 32'hFF);
    for (int k = 0; k < 17; k++) tick();
    check("mid bit3 tx", {31'd0, tx}, 32'd1);
    check("mid bit3 busy", {31'd0, tx_busy}, 32'd1);
    rd_check("mid status", BASE + 32'h4, 32'h14, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort tx", {31'd0, tx}, 32'd1);
    check("abort busy", {31'd0, tx_busy}, 32'd0);
    rd_check("abort status", BASE + 32'h4, 32'h2, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("post abort line cyc %0d", k), {30'd0, tx, tx_busy}, {30'd0, 2'b10});
    end
    rd_check("post abort miss", 32'h0000_1000, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
